// File: rtl/stc_pkg.sv
// stc_pkg: state encoding and default parameters shared by the tile sequencer.
package stc_pkg;
  localparam int STC_M      = 16;
  localparam int STC_K      = 16;
  localparam int STC_DW_MEM = 512;
  localparam int STC_DW_IDX = 4;
  localparam int STC_DW_CNT = 8;
  typedef enum logic [2:0] {IDLE, LD_CU, LD_AD, LD_AC, LD_B, LD_C, RUN, FIN} stc_state_e;
endpackage

// File: rtl/stc_beat_counter.sv
// stc_beat_counter: loadable up-counter with optional saturation and a terminal-count flag.
module stc_beat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         sat,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : (inc && !(sat && &cnt_q)) ? cnt_q + W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
  assign cnt = cnt_q;
  assign tc  = cnt_q == term;
endmodule

// File: rtl/stc_tile_seq.sv
// stc_tile_seq: loads one tile (CU, A data, A colidx, B, C) from a beat stream into the core,
// then waits for M result rows and pulses done.
module stc_tile_seq
  import stc_pkg::*;
#(
  parameter int M      = STC_M,
  parameter int K      = STC_K,
  parameter int DW_MEM = STC_DW_MEM,
  parameter int DW_IDX = STC_DW_IDX,
  parameter int DW_CNT = STC_DW_CNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DW_IDX:0]   cfg_a_beats,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW_MEM-1:0] s_data,
  output logic              write_cu,
  output logic              write_a_data_en,
  output logic              write_a_cidx_en,
  output logic [DW_IDX-1:0] A_idx,
  output logic              write_b,
  output logic [DW_IDX-1:0] B_row,
  output logic              write_c,
  output logic [DW_IDX-1:0] in_c_row,
  output logic [DW_MEM-1:0] core_data,
  input  logic              core_out_valid,
  output logic              busy,
  output logic              done,
  output logic [DW_CNT-1:0] rows_seen
);
  localparam int BW = DW_IDX + 1;
  stc_state_e        state_q, state_d;
  logic [BW-1:0]     a_beats_q, a_beats_d;
  logic [DW_IDX-1:0] idx_cnt, idx_term;
  logic              idx_tc, idx_load, rows_tc, rows_load, accept, last;
  // The index counter's terminal count is the last beat number of the current load phase,
  // so a 2^DW_IDX-beat phase ends at index 2^DW_IDX-1 and the index wraps on reload.
  always_comb begin
    s_ready   = state_q inside {LD_CU, LD_AD, LD_AC, LD_B, LD_C};
    accept    = s_valid & s_ready;
    idx_term  = (state_q == LD_AD || state_q == LD_AC) ? DW_IDX'(a_beats_q - BW'(1)) :
                state_q == LD_B ? DW_IDX'(K - 1) :
                state_q == LD_C ? DW_IDX'(M - 1) : '0;
    last      = accept & idx_tc;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LD_CU;
      LD_CU:   if (last) state_d = (a_beats_q == '0) ? LD_B : LD_AD;
      LD_AD:   if (last) state_d = LD_AC;
      LD_AC:   if (last) state_d = LD_B;
      LD_B:    if (last) state_d = LD_C;
      LD_C:    if (last) state_d = RUN;
      RUN:     if (core_out_valid && rows_tc) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rows_load = state_q == IDLE && start;
    a_beats_d = rows_load ? cfg_a_beats : a_beats_q;
    idx_load  = state_d != state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_beats_q <= '0;
    end else begin
      state_q   <= state_d;
      a_beats_q <= a_beats_d;
    end
  end
  stc_beat_counter #(.W(DW_IDX)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load),
    .load_val ('0),
    .inc      (accept),
    .sat      (1'b0),
    .term     (idx_term),
    .cnt      (idx_cnt),
    .tc       (idx_tc)
  );
  stc_beat_counter #(.W(DW_CNT)) u_rows (
    .clk      (clk),
    .reset    (reset),
    .load     (rows_load),
    .load_val ('0),
    .inc      (core_out_valid),
    .sat      (1'b1),
    .term     (DW_CNT'(M - 1)),
    .cnt      (rows_seen),
    .tc       (rows_tc)
  );
  assign write_cu        = accept && state_q == LD_CU;
  assign write_a_data_en = accept && state_q == LD_AD;
  assign write_a_cidx_en = accept && state_q == LD_AC;
  assign write_b         = accept && state_q == LD_B;
  assign write_c         = accept && state_q == LD_C;
  assign A_idx           = idx_cnt;
  assign B_row           = idx_cnt;
  assign in_c_row        = idx_cnt;
  assign core_data       = s_data;
  assign busy            = state_q != IDLE;
  assign done            = state_q == FIN;
endmodule

// File: tb/tb_stc_tile_seq.sv
// tb_stc_tile_seq: directed tiles checked every cycle against a flat beat-list model.
module tb_stc_tile_seq;
  localparam int M = 16, K = 16, DW_MEM = 512, DW_IDX = 4, DW_CNT = 8;
  logic clk = 0, reset = 1, start = 0, s_valid = 0, core_out_valid = 0;
  logic [DW_IDX:0] cfg_a_beats = '0;
  logic [DW_MEM-1:0] s_data = '0;
  logic s_ready, write_cu, write_a_data_en, write_a_cidx_en, write_b, write_c, busy, done;
  logic [DW_IDX-1:0] A_idx, B_row, in_c_row;
  logic [DW_MEM-1:0] core_data;
  logic [DW_CNT-1:0] rows_seen;
  always #5 clk = ~clk;
  stc_tile_seq dut (
    .clk(clk), .reset(reset), .start(start), .cfg_a_beats(cfg_a_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .write_cu(write_cu), .write_a_data_en(write_a_data_en), .write_a_cidx_en(write_a_cidx_en),
    .A_idx(A_idx), .write_b(write_b), .B_row(B_row), .write_c(write_c), .in_c_row(in_c_row),
    .core_data(core_data), .core_out_valid(core_out_valid), .busy(busy), .done(done),
    .rows_seen(rows_seen)
  );
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Model: phase 0 idle, 1 loading, 2 waiting rows, 3 finishing; a tile is a flat list of beats.
  int m_phase = 0, m_pos = 0, m_a = 0, m_rows = 0, cyc = 0;
  int t_cu = 0, t_ad = 0, t_ac = 0, t_b = 0, t_c = 0, t_beats = 0, t_done = 0;
  int last_cov_cyc = 0, done_cyc = 0;
  always @(negedge clk) begin
    int p, e_k, e_i, nr;
    cyc++;
    p = m_pos; e_k = 0; e_i = 0;
    if (m_phase == 1 && s_valid) begin
      if (p == 0) e_k = 1;
      else if (p <= m_a) begin e_k = 2; e_i = p - 1; end
      else if (p <= 2 * m_a) begin e_k = 3; e_i = p - 1 - m_a; end
      else if (p <= 2 * m_a + K) begin e_k = 4; e_i = p - 1 - 2 * m_a; end
      else begin e_k = 5; e_i = p - 1 - 2 * m_a - K; end
    end
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_phase == 3);
    chk("s_ready", s_ready, m_phase == 1);
    chk("rows_seen", rows_seen, m_rows);
    chk("write_cu", write_cu, e_k == 1);
    chk("write_a_data_en", write_a_data_en, e_k == 2);
    chk("write_a_cidx_en", write_a_cidx_en, e_k == 3);
    chk("write_b", write_b, e_k == 4);
    chk("write_c", write_c, e_k == 5);
    if (e_k == 2 || e_k == 3) chk("A_idx", A_idx, e_i % 16);
    if (e_k == 4) chk("B_row", B_row, e_i % 16);
    if (e_k == 5) chk("in_c_row", in_c_row, e_i % 16);
    if (e_k != 0) begin
      n_cmp++;
      if (core_data !== s_data) begin
        n_err++;
        $display("FAIL core_data: got %0h expected %0h", core_data[63:0], s_data[63:0]);
      end
    end
    t_cu += int'(write_cu); t_ad += int'(write_a_data_en); t_ac += int'(write_a_cidx_en);
    t_b += int'(write_b); t_c += int'(write_c); t_beats += int'(s_valid & s_ready);
    t_done += int'(done);
    if (core_out_valid) last_cov_cyc = cyc;
    if (done) done_cyc = cyc;
    nr = (m_phase == 0 && start) ? 0 : (core_out_valid && m_rows < 255) ? m_rows + 1 : m_rows;
    if (reset) begin
      m_phase = 0; m_pos = 0; nr = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_pos = 0; m_a = int'(cfg_a_beats); end
        1: if (s_valid) begin
             m_pos++;
             if (m_pos == 1 + 2 * m_a + K + M) m_phase = 2;
           end
        2: if (core_out_valid && m_rows == M - 1) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    m_rows = nr;
  end
  int b_cu, b_ad, b_ac, b_b, b_c, b_beats, b_done;
  task automatic snap();
    b_cu = t_cu; b_ad = t_ad; b_ac = t_ac; b_b = t_b; b_c = t_c; b_beats = t_beats; b_done = t_done;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic tile_start(input int a);
    cfg_a_beats = (DW_IDX + 1)'(a); start = 1; step(); start = 0;
  endtask
  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = {16{$urandom}}; step();
    end
    s_valid = 0;
  endtask
  task automatic rows16();
    for (int i = 0; i < 16; i++) begin core_out_valid = 1; step(); end
    core_out_valid = 0; step(); step();
  endtask
  initial begin
    reset = 1; repeat (3) step(); reset = 0;
    chk("rst_ready", s_ready, 0); chk("rst_busy", busy, 0);
    chk("rst_rows", rows_seen, 0); chk("rst_done", done, 0);
    snap(); tile_start(3); beats(39);
    chk("s1_cu", t_cu - b_cu, 1); chk("s1_ad", t_ad - b_ad, 3); chk("s1_ac", t_ac - b_ac, 3);
    chk("s1_b", t_b - b_b, 16); chk("s1_c", t_c - b_c, 16); chk("s1_beats", t_beats - b_beats, 39);
    chk("s1_busy", busy, 1); chk("s1_ready_after", s_ready, 0);
    snap(); rows16();
    chk("s4_done_cnt", t_done - b_done, 1); chk("s4_done_lag", done_cyc - last_cov_cyc, 1);
    chk("s4_rows", rows_seen, 16); chk("s4_busy", busy, 0);
    snap(); tile_start(0); beats(33);
    chk("s2_ad", t_ad - b_ad, 0); chk("s2_ac", t_ac - b_ac, 0);
    chk("s2_b", t_b - b_b, 16); chk("s2_c", t_c - b_c, 16);
    rows16();
    snap(); tile_start(1); beats(3);
    for (int i = 0; i < 32; i++) begin
      s_valid = (i % 2 == 0); s_data = {16{$urandom}}; step();
    end
    s_valid = 0;
    chk("s3_b", t_b - b_b, 16);
    beats(16); chk("s3_c", t_c - b_c, 16); rows16();
    snap(); tile_start(2); beats(10);
    chk("s5_brow", B_row, 5);
    reset = 1; step(); reset = 0;
    chk("s5_ready", s_ready, 0); chk("s5_busy", busy, 0);
    step(); chk("s5_no_done", t_done - b_done, 0);
    snap(); tile_start(2); beats(37); rows16();
    chk("s5_replay_b", t_b - b_b, 16); chk("s5_replay_done", t_done - b_done, 1);
    snap(); tile_start(3); beats(5);
    start = 1; cfg_a_beats = '0; step(); start = 0;
    chk("s6_aidx", A_idx, 1); chk("s6_ready", s_ready, 1);
    beats(34);
    chk("s6_ac", t_ac - b_ac, 3); chk("s6_b", t_b - b_b, 16);
    rows16();
    snap(); tile_start(16); beats(65);
    chk("s7_ad", t_ad - b_ad, 16); chk("s7_ac", t_ac - b_ac, 16); chk("s7_c", t_c - b_c, 16);
    rows16();
    core_out_valid = 1; repeat (260) step(); core_out_valid = 0;
    chk("sat_rows", rows_seen, 255); chk("sat_busy", busy, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
